// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and helpers for the branch predictor.
// The PHT uses 2-bit saturating counters; bit 1 of a counter is the taken prediction.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_state_t;

  function automatic pht_state_t sat_inc(input pht_state_t s);
    case (s)
      SNT:     return WNT;
      WNT:     return WT;
      default: return ST;
    endcase
  endfunction

  function automatic pht_state_t sat_dec(input pht_state_t s);
    case (s)
      ST:      return WT;
      WT:      return WNT;
      default: return SNT;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pht_table.sv
// Pattern history table: one combinational lookup port and one synchronous
// training port that applies a saturating step to the addressed counter.
module branch_resolve_unit_pht_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int         IDX_W      = 6,
  parameter pht_state_t INIT_STATE = WNT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output pht_state_t       rd_state_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int DEPTH = 2 ** IDX_W;

  pht_state_t entries_q [DEPTH];

  // No bypass: a lookup that collides with training sees the old value.
  assign rd_state_o = entries_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= INIT_STATE;
      end
    end else if (wr_en_i) begin
      entries_q[wr_idx_i] <= wr_taken_i ? sat_inc(entries_q[wr_idx_i])
                                        : sat_dec(entries_q[wr_idx_i]);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: PHT lookup for ID, mispredict detection, redirect and
// training for EX, plus saturating branch / mispredict statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int         IDX_W      = 6,
  parameter int         CNT_W      = 32,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_branch_i,
  input  logic [31:0]      id_pc_i,
  output logic             predict_taken_o,
  input  logic             ex_branch_i,
  input  logic             ex_predict_taken_i,
  input  logic             ex_taken_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_pc_otherwise_i,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  pht_state_t       rd_state;
  logic             mispredict;

  logic [CNT_W-1:0] branch_cnt_q,     branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  // Word-aligned PCs: byte offset and bits above the index take no part.
  assign rd_idx = id_pc_i[IDX_W+1:2];
  assign wr_idx = ex_pc_i[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{id_pc_i[31:IDX_W+2], id_pc_i[1:0],
                            ex_pc_i[31:IDX_W+2], ex_pc_i[1:0]};

  branch_resolve_unit_pht_table #(
    .IDX_W      (IDX_W),
    .INIT_STATE (pht_state_t'(INIT_STATE))
  ) u_pht (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (rd_idx),
    .rd_state_o (rd_state),
    .wr_en_i    (ex_branch_i),
    .wr_idx_i   (wr_idx),
    .wr_taken_i (ex_taken_i)
  );

  assign predict_taken_o = id_branch_i & rd_state[1];

  assign mispredict       = ex_branch_i & (ex_taken_i != ex_predict_taken_i);
  assign flush_o          = rst_i & mispredict;
  assign redirect_valid_o = flush_o;
  assign redirect_pc_o    = flush_o ? ex_pc_otherwise_i : 32'd0;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (ex_branch_i && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredict && (mispredict_cnt_q != {CNT_W{1'b1}})) begin
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a second instance with 3-bit
// counters shares the stimulus so counter saturation is reached quickly.
module tb_branch_resolve_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_branch_i;
  logic [31:0] id_pc_i;
  logic        ex_branch_i;
  logic        ex_predict_taken_i;
  logic        ex_taken_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_pc_otherwise_i;

  logic        predict_taken_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  logic        unused_s_predict;
  logic        unused_s_flush;
  logic        unused_s_rvalid;
  logic [31:0] unused_s_rpc;
  logic [2:0]  s_branch_cnt;
  logic [2:0]  s_mispredict_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  branch_resolve_unit dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .id_branch_i        (id_branch_i),
    .id_pc_i            (id_pc_i),
    .predict_taken_o    (predict_taken_o),
    .ex_branch_i        (ex_branch_i),
    .ex_predict_taken_i (ex_predict_taken_i),
    .ex_taken_i         (ex_taken_i),
    .ex_pc_i            (ex_pc_i),
    .ex_pc_otherwise_i  (ex_pc_otherwise_i),
    .flush_o            (flush_o),
    .redirect_valid_o   (redirect_valid_o),
    .redirect_pc_o      (redirect_pc_o),
    .branch_cnt_o       (branch_cnt_o),
    .mispredict_cnt_o   (mispredict_cnt_o)
  );

  branch_resolve_unit #(.CNT_W(3)) dut_small (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .id_branch_i        (id_branch_i),
    .id_pc_i            (id_pc_i),
    .predict_taken_o    (unused_s_predict),
    .ex_branch_i        (ex_branch_i),
    .ex_predict_taken_i (ex_predict_taken_i),
    .ex_taken_i         (ex_taken_i),
    .ex_pc_i            (ex_pc_i),
    .ex_pc_otherwise_i  (ex_pc_otherwise_i),
    .flush_o            (unused_s_flush),
    .redirect_valid_o   (unused_s_rvalid),
    .redirect_pc_o      (unused_s_rpc),
    .branch_cnt_o       (s_branch_cnt),
    .mispredict_cnt_o   (s_mispredict_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Commit the current inputs at the next rising edge, then settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred);
    ex_branch_i        = 1'b1;
    ex_pc_i            = pc;
    ex_taken_i         = taken;
    ex_predict_taken_i = pred;
    #2;
  endtask

  initial begin
    rst_i              = 1'b0;
    id_branch_i        = 1'b0;
    id_pc_i            = 32'd0;
    ex_branch_i        = 1'b0;
    ex_predict_taken_i = 1'b0;
    ex_taken_i         = 1'b0;
    ex_pc_i            = 32'd0;
    ex_pc_otherwise_i  = 32'd0;

    // 1. reset and full-table lookup
    tick();
    tick();
    rst_i = 1'b1;
    #2;
    check("rst_bcnt", 64'(branch_cnt_o), 64'd0);
    check("rst_mcnt", 64'(mispredict_cnt_o), 64'd0);
    for (int i = 0; i < 64; i++) begin
      id_branch_i = 1'b1;
      id_pc_i     = 32'(i) << 2;
      #1;
      check($sformatf("rst_pred_idx%0d", i), 64'(predict_taken_o), 64'd0);
      check($sformatf("rst_flush_idx%0d", i), 64'(flush_o), 64'd0);
    end
    id_branch_i = 1'b0;

    // 2. train pc 0x40 (idx 16) taken three times
    check("tr_entry_init", 64'(dut.u_pht.entries_q[16]), 64'h1);
    ex_pc_otherwise_i = 32'h44;
    resolve(32'h40, 1'b1, 1'b0);
    check("tr1_flush", 64'(flush_o), 64'd1);
    tick();
    check("tr1_entry", 64'(dut.u_pht.entries_q[16]), 64'h2);
    resolve(32'h40, 1'b1, 1'b1);
    check("tr2_flush", 64'(flush_o), 64'd0);
    tick();
    check("tr2_entry", 64'(dut.u_pht.entries_q[16]), 64'h3);
    resolve(32'h40, 1'b1, 1'b1);
    check("tr3_flush", 64'(flush_o), 64'd0);
    tick();
    check("tr3_entry", 64'(dut.u_pht.entries_q[16]), 64'h3);
    check("tr_bcnt", 64'(branch_cnt_o), 64'd3);
    check("tr_mcnt", 64'(mispredict_cnt_o), 64'd1);
    ex_branch_i = 1'b0;

    // 3. redirect, then the same inputs without a valid branch
    ex_pc_otherwise_i = 32'h104;
    resolve(32'h200, 1'b0, 1'b1);
    check("rd_flush", 64'(flush_o), 64'd1);
    check("rd_valid", 64'(redirect_valid_o), 64'd1);
    check("rd_pc", 64'(redirect_pc_o), 64'h104);
    ex_branch_i = 1'b0;
    #1;
    check("rd_nb_flush", 64'(flush_o), 64'd0);
    check("rd_nb_valid", 64'(redirect_valid_o), 64'd0);
    check("rd_nb_pc", 64'(redirect_pc_o), 64'd0);
    tick();
    check("rd_bcnt", 64'(branch_cnt_o), 64'd3);

    // 4. same-index lookup and train at 0x80 (idx 32)
    id_branch_i = 1'b1;
    id_pc_i     = 32'h80;
    resolve(32'h80, 1'b1, 1'b0);
    check("col_pred_same", 64'(predict_taken_o), 64'd0);
    tick();
    ex_branch_i = 1'b0;
    #1;
    check("col_pred_next", 64'(predict_taken_o), 64'd1);
    id_branch_i = 1'b0;
    #1;
    check("col_pred_gated", 64'(predict_taken_o), 64'd0);
    check("col_bcnt", 64'(branch_cnt_o), 64'd4);
    check("col_mcnt", 64'(mispredict_cnt_o), 64'd2);

    // 5. aliasing 0x0 / 0x100 not-taken, then counter saturation
    resolve(32'h0, 1'b0, 1'b0);
    tick();
    check("al1_entry", 64'(dut.u_pht.entries_q[0]), 64'h0);
    resolve(32'h100, 1'b0, 1'b0);
    tick();
    resolve(32'h0, 1'b0, 1'b0);
    tick();
    resolve(32'h100, 1'b0, 1'b0);
    tick();
    ex_branch_i = 1'b0;
    check("al4_entry", 64'(dut.u_pht.entries_q[0]), 64'h0);
    id_branch_i = 1'b1;
    id_pc_i     = 32'h100;
    #1;
    check("al_pred", 64'(predict_taken_o), 64'd0);
    id_branch_i = 1'b0;
    check("sat_bcnt_main8", 64'(branch_cnt_o), 64'd8);
    check("sat_bcnt_small8", 64'(s_branch_cnt), 64'd7);
    resolve(32'h0, 1'b0, 1'b0);
    tick();
    ex_branch_i = 1'b0;
    check("sat_bcnt_main9", 64'(branch_cnt_o), 64'd9);
    check("sat_bcnt_small9", 64'(s_branch_cnt), 64'd7);
    check("sat_mcnt_small", 64'(s_mispredict_cnt), 64'd2);

    // 6. reset during a pending mispredict at 0xC0 (idx 48)
    ex_pc_otherwise_i = 32'h300;
    resolve(32'hC0, 1'b1, 1'b0);
    rst_i = 1'b0;
    #1;
    check("mr_flush", 64'(flush_o), 64'd0);
    check("mr_valid", 64'(redirect_valid_o), 64'd0);
    check("mr_pc", 64'(redirect_pc_o), 64'd0);
    tick();
    check("mr_entry48", 64'(dut.u_pht.entries_q[48]), 64'h1);
    check("mr_entry16", 64'(dut.u_pht.entries_q[16]), 64'h1);
    check("mr_bcnt", 64'(branch_cnt_o), 64'd0);
    check("mr_mcnt", 64'(mispredict_cnt_o), 64'd0);
    rst_i       = 1'b1;
    ex_branch_i = 1'b0;
    tick();
    check("mr_bcnt_after", 64'(branch_cnt_o), 64'd0);
    check("mr_small_bcnt", 64'(s_branch_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
